// File: rtl/ami_pkg.sv
// Shared AMI/AXI definitions: burst and response encodings, write-splitter
// FSM states and the 4KB boundary helper used for burst sizing.
package ami_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    WAIT_B = 2'b10,
    DONE   = 2'b11
  } wcmd_state_e;

  // Beats of (1 << size_lg) bytes that fit before the next 4KB page boundary.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                              input int unsigned size_lg);
    return (13'd4096 - {1'b0, addr_lo}) >> size_lg;
  endfunction

endpackage

// File: rtl/ami_wcmd_split.sv
// Splits a write command of arbitrary beat count into AXI INCR bursts that
// respect MAX_BEATS, the 4KB page rule and a cap on outstanding B responses.
module ami_wcmd_split
  import ami_pkg::*;
#(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 32,
  parameter int AXI_IW    = 8,
  parameter int AXI_LW    = 8,
  parameter int AXI_SW    = 3,
  parameter int AMI_OD    = 4,
  parameter int MAX_BEATS = 16,
  parameter int CMD_LW    = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [AXI_IW-1:0] cmd_id,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [CMD_LW-1:0] cmd_beats,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [AXI_IW-1:0] usr_awid,
  output logic [AXI_AW-1:0] usr_awaddr,
  output logic [AXI_LW-1:0] usr_awlen,
  output logic [AXI_SW-1:0] usr_awsize,
  output logic [1:0]        usr_awburst,
  output logic              usr_awvalid,
  input  logic              usr_awready,
  input  logic [AXI_IW-1:0] usr_bid,
  input  logic [1:0]        usr_bresp,
  input  logic              usr_bvalid,
  output logic              usr_bready,
  output logic [1:0]        done_resp,
  output logic              done_valid,
  input  logic              done_ready
);

  localparam int BPB_LG = $clog2(AXI_DW / 8);
  localparam int OW     = $clog2(AMI_OD + 1);
  localparam int W0     = (CMD_LW > 13) ? CMD_LW : 13;
  localparam int W1     = (W0 > AXI_LW + 1) ? W0 : AXI_LW + 1;
  localparam int BW     = W1 + 1;

  wcmd_state_e       state_q, state_d;
  logic [AXI_IW-1:0] id_q;
  logic [AXI_AW-1:0] addr_q;
  logic [CMD_LW-1:0] rem_q;
  logic [OW-1:0]     out_q;
  logic [1:0]        err_q;
  logic              rdy_q;

  logic [BW-1:0]     rem_ext, bnd_ext, len;
  logic [CMD_LW-1:0] rem_next;
  logic [AXI_AW-1:0] addr_step;
  logic              aw_fire, b_fire, cmd_fire, aw_act;
  logic              unused_bid;

  assign unused_bid = ^usr_bid;

  // Burst length is the tightest of remaining beats, MAX_BEATS and the page room.
  always_comb begin
    rem_ext = BW'(rem_q);
    bnd_ext = BW'(beats_to_4k(addr_q[11:0], BPB_LG));
    len     = rem_ext;
    if (BW'(MAX_BEATS) < len) len = BW'(MAX_BEATS);
    if (bnd_ext < len) len = bnd_ext;
  end

  assign rem_next  = rem_q - CMD_LW'(len);
  assign addr_step = AXI_AW'(len) << BPB_LG;
  assign aw_fire   = usr_awvalid && usr_awready;
  assign b_fire    = usr_bvalid && usr_bready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_act    = (state_q == ISSUE);

  assign usr_awid    = id_q;
  assign usr_awaddr  = addr_q;
  assign usr_awlen   = aw_act ? AXI_LW'(len - BW'(1)) : '0;
  assign usr_awsize  = aw_act ? AXI_SW'(BPB_LG) : '0;
  assign usr_awburst = aw_act ? BURST_INCR : BURST_FIXED;
  assign done_resp   = (state_q == DONE) ? err_q : 2'b00;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    usr_awvalid = 1'b0;
    usr_bready  = 1'b0;
    done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rdy_q;
        if (cmd_valid && rdy_q) state_d = (cmd_beats == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        usr_awvalid = (out_q < OW'(AMI_OD));
        usr_bready  = 1'b1;
        if ((out_q < OW'(AMI_OD)) && usr_awready && (rem_next == '0))
          state_d = WAIT_B;
      end
      WAIT_B: begin
        usr_bready = 1'b1;
        if (out_q == '0) state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command context; an AW and a B in the same cycle cancel in the counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdy_q  <= 1'b0;
      id_q   <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      out_q  <= '0;
      err_q  <= 2'b00;
    end else begin
      rdy_q <= 1'b1;
      if (cmd_fire) begin
        id_q   <= cmd_id;
        addr_q <= cmd_addr;
        rem_q  <= cmd_beats;
        out_q  <= '0;
        err_q  <= 2'b00;
      end else begin
        if (aw_fire) begin
          addr_q <= addr_q + addr_step;
          rem_q  <= rem_next;
        end
        if (aw_fire && !b_fire)
          out_q <= out_q + OW'(1);
        else if (!aw_fire && b_fire && (out_q != '0))
          out_q <= out_q - OW'(1);
        if (b_fire && (usr_bresp > err_q))
          err_q <= usr_bresp;
      end
    end
  end

endmodule

// File: tb/tb_ami_wcmd_split.sv
// Directed bench for ami_wcmd_split (128-bit data, 16-beat bursts, 4 outstanding).
module tb_ami_wcmd_split;
  import ami_pkg::*;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  usr_awid;
  logic [31:0] usr_awaddr;
  logic [7:0]  usr_awlen;
  logic [2:0]  usr_awsize;
  logic [1:0]  usr_awburst;
  logic        usr_awvalid;
  logic        usr_awready;
  logic [7:0]  usr_bid;
  logic [1:0]  usr_bresp;
  logic        usr_bvalid;
  logic        usr_bready;
  logic [1:0]  done_resp;
  logic        done_valid;
  logic        done_ready;

  int checks = 0;
  int errors = 0;

  int          aw_cnt = 0;
  int          cross_err = 0;
  int          stab_err = 0;
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic        pend = 1'b0;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [7:0]  p_id;

  ami_wcmd_split #(
    .AXI_DW(128), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .AXI_SW(3),
    .AMI_OD(4), .MAX_BEATS(16), .CMD_LW(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
    .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
    .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
    .usr_bready(usr_bready),
    .done_resp(done_resp), .done_valid(done_valid), .done_ready(done_ready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Log every AW handshake, and flag page crossings or fields moving under stall.
  always @(negedge ACLK) begin
    if (usr_awvalid && usr_awready) begin
      aw_addr_log.push_back(usr_awaddr);
      aw_len_log.push_back(usr_awlen);
      aw_cnt = aw_cnt + 1;
      if (int'(usr_awaddr[11:0]) + (int'(usr_awlen) + 1) * 16 > 4096)
        cross_err = cross_err + 1;
    end
    if (pend && usr_awvalid &&
        (usr_awaddr != p_addr || usr_awlen != p_len || usr_awid != p_id))
      stab_err = stab_err + 1;
    pend   = usr_awvalid && !usr_awready;
    p_addr = usr_awaddr;
    p_len  = usr_awlen;
    p_id   = usr_awid;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] id, input logic [31:0] addr,
                               input logic [15:0] beats);
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_beats = beats;
    cmd_valid = 1'b1;
    @(negedge ACLK);
    checkOutput("cmd_ready", cmd_ready, 1);
    @(posedge ACLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    usr_bvalid = 1'b1;
    usr_bresp  = resp;
    @(negedge ACLK);
    checkOutput("bready", usr_bready, 1);
    @(posedge ACLK);
    #1 usr_bvalid = 1'b0;
  endtask

  task automatic wait_aw(input int n, input int base);
    int k = 0;
    while ((aw_cnt - base) < n && k < 200) begin
      @(posedge ACLK);
      k++;
    end
    #1;
    checkOutput("aw_count_reached", aw_cnt - base, n);
  endtask

  task automatic wait_done(input logic [1:0] exp);
    int k = 0;
    @(negedge ACLK);
    while (!done_valid && k < 200) begin
      @(negedge ACLK);
      k++;
    end
    checkOutput("done_valid", done_valid, 1);
    checkOutput("done_resp", done_resp, exp);
    done_ready = 1'b1;
    @(posedge ACLK);
    #1 done_ready = 1'b0;
  endtask

  initial begin
    int base;
    ARESETn     = 1'b0;
    cmd_id      = '0;
    cmd_addr    = '0;
    cmd_beats   = '0;
    cmd_valid   = 1'b0;
    usr_awready = 1'b0;
    usr_bid     = '0;
    usr_bresp   = 2'b00;
    usr_bvalid  = 1'b0;
    done_ready  = 1'b0;

    // Reset values, including cmd_ready held low across a clock edge.
    #12;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_awvalid", usr_awvalid, 0);
    checkOutput("rst_bready", usr_bready, 0);
    checkOutput("rst_done_valid", done_valid, 0);
    checkOutput("rst_done_resp", done_resp, 0);
    checkOutput("rst_awaddr", usr_awaddr, 0);
    checkOutput("rst_awlen", usr_awlen, 0);
    checkOutput("rst_awsize", usr_awsize, 0);
    checkOutput("rst_awburst", usr_awburst, 0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge ACLK);
    #1;

    // 40 beats from 0x1000 -> 16 + 16 + 8.
    base = aw_cnt;
    usr_awready = 1'b1;
    applyStimulus(8'h11, 32'h1000, 16'd40);
    @(negedge ACLK);
    checkOutput("t1_awvalid", usr_awvalid, 1);
    checkOutput("t1_awid", usr_awid, 8'h11);
    checkOutput("t1_awsize", usr_awsize, 3'd4);
    checkOutput("t1_awburst", usr_awburst, 2'b01);
    wait_aw(3, base);
    checkOutput("t1_aw0_addr", aw_addr_log[base],     32'h1000);
    checkOutput("t1_aw0_len",  aw_len_log[base],      8'd15);
    checkOutput("t1_aw1_addr", aw_addr_log[base + 1], 32'h1100);
    checkOutput("t1_aw1_len",  aw_len_log[base + 1],  8'd15);
    checkOutput("t1_aw2_addr", aw_addr_log[base + 2], 32'h1200);
    checkOutput("t1_aw2_len",  aw_len_log[base + 2],  8'd7);
    send_b(RESP_OKAY);
    send_b(RESP_OKAY);
    send_b(RESP_OKAY);
    wait_done(2'b00);
    checkOutput("t1_aw_total", aw_cnt - base, 3);

    // 10 beats from 0x1FC0 -> 4 beats to the page edge, then 6.
    base = aw_cnt;
    applyStimulus(8'h12, 32'h1FC0, 16'd10);
    wait_aw(2, base);
    checkOutput("t2_aw0_addr", aw_addr_log[base],     32'h1FC0);
    checkOutput("t2_aw0_len",  aw_len_log[base],      8'd3);
    checkOutput("t2_aw1_addr", aw_addr_log[base + 1], 32'h2000);
    checkOutput("t2_aw1_len",  aw_len_log[base + 1],  8'd5);
    send_b(RESP_OKAY);
    send_b(RESP_OKAY);
    wait_done(2'b00);

    // 128 beats with B withheld: stalls at 4 outstanding.
    base = aw_cnt;
    applyStimulus(8'h22, 32'h0, 16'd128);
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("t3_aw_at_limit", aw_cnt - base, 4);
    checkOutput("t3_awvalid_low", usr_awvalid, 0);
    @(posedge ACLK);
    #1;
    send_b(RESP_OKAY);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("t3_fifth_aw", aw_cnt - base, 5);
    checkOutput("t3_aw4_addr", aw_addr_log[base + 4], 32'h400);
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 7; i++) begin
      send_b(RESP_OKAY);
      repeat (2) @(posedge ACLK);
      #1;
    end
    wait_done(2'b00);
    checkOutput("t3_aw_total", aw_cnt - base, 8);

    // 3 bursts: SLVERR coincides with the last AW, DECERR last.
    base = aw_cnt;
    applyStimulus(8'h33, 32'h3000, 16'd48);
    wait_aw(2, base);
    usr_awready = 1'b0;
    send_b(RESP_OKAY);
    usr_awready = 1'b1;
    usr_bvalid  = 1'b1;
    usr_bresp   = RESP_SLVERR;
    @(negedge ACLK);
    checkOutput("t4_aw_and_b", {usr_awvalid, usr_bready}, 2'b11);
    @(posedge ACLK);
    #1;
    usr_awready = 1'b0;
    usr_bvalid  = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("t4_no_early_done", done_valid, 0);
    checkOutput("t4_aw2_addr", aw_addr_log[base + 2], 32'h3200);
    @(posedge ACLK);
    #1;
    send_b(RESP_DECERR);
    wait_done(2'b11);
    checkOutput("t4_aw_total", aw_cnt - base, 3);

    // Zero-beat command.
    base = aw_cnt;
    applyStimulus(8'h44, 32'h5000, 16'd0);
    @(negedge ACLK);
    checkOutput("t5_done_next", done_valid, 1);
    checkOutput("t5_done_resp", done_resp, 0);
    checkOutput("t5_no_awvalid", usr_awvalid, 0);
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("t5_done_held", done_valid, 1);
    done_ready = 1'b1;
    @(posedge ACLK);
    #1 done_ready = 1'b0;
    @(negedge ACLK);
    checkOutput("t5_done_cleared", done_valid, 0);
    checkOutput("t5_no_aw", aw_cnt - base, 0);
    @(posedge ACLK);
    #1;

    // Reset in the middle of ISSUE, then a clean command.
    applyStimulus(8'h55, 32'h4000, 16'd64);
    @(negedge ACLK);
    checkOutput("t6_awvalid_pre", usr_awvalid, 1);
    #2 ARESETn = 1'b0;
    #1;
    checkOutput("t6_rst_awvalid", usr_awvalid, 0);
    checkOutput("t6_rst_bready", usr_bready, 0);
    checkOutput("t6_rst_done_valid", done_valid, 0);
    checkOutput("t6_rst_cmd_ready", cmd_ready, 0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("t6_cmd_ready_wait", cmd_ready, 0);
    @(posedge ACLK);
    #1;
    base = aw_cnt;
    usr_awready = 1'b1;
    applyStimulus(8'h66, 32'h0, 16'd16);
    @(negedge ACLK);
    checkOutput("t6_awid", usr_awid, 8'h66);
    checkOutput("t6_awaddr", usr_awaddr, 32'h0);
    checkOutput("t6_awlen", usr_awlen, 8'd15);
    wait_aw(1, base);
    send_b(RESP_EXOKAY);
    wait_done(2'b01);
    checkOutput("t6_aw_total", aw_cnt - base, 1);

    checkOutput("aw_stable", stab_err, 0);
    checkOutput("no_4k_cross", cross_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
